// File: rtl/load_unit_if.sv
// Load unit port bundle: request, memory beat and writeback response channels.
// master = the load unit side, slave = the pipeline/memory environment side.
`timescale 1ns/1ps
interface load_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_op;
    logic [TAG_W-1:0]  req_tag;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic [TAG_W-1:0]  resp_tag;
    logic              resp_adel;

    modport master (
        input  req_valid, req_addr, req_op, req_tag,
        output req_ready,
        output mem_req_valid, mem_addr,
        input  mem_req_ready, mem_rvalid, mem_rdata,
        output resp_valid, resp_data, resp_tag, resp_adel,
        input  resp_ready
    );

    modport slave (
        output req_valid, req_addr, req_op, req_tag,
        input  req_ready,
        input  mem_req_valid, mem_addr,
        output mem_req_ready, mem_rvalid, mem_rdata,
        input  resp_valid, resp_data, resp_tag, resp_adel,
        output resp_ready
    );
endinterface

// File: rtl/load_unit.sv
// Sequential load unit: beat reads, byte select, zero/sign extend; LOAD_MISALIGN_SPLIT_EN merges boundary-spanning beats.
// Latency: 3 cycles best case, +2 per extra beat plus memory stalls; reserved/error path answers 1 cycle after accept.
// Backpressure: one request at a time (req_ready only when idle); beat request held until mem_req_ready; response held until resp_ready.
`timescale 1ns/1ps
module load_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic        clk,
    input  logic        reset,
    load_unit_if.master lu
);
    localparam int BYTES  = DATA_W / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int OFF_W1 = OFF_W + 1;
`ifdef LOAD_MISALIGN_SPLIT_EN
    localparam int BUF_W  = 2 * DATA_W;
`else
    localparam int BUF_W  = DATA_W;
`endif

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LB  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LH  = 3'd4;

`ifdef LOAD_MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, BEAT0, RESP} state_t;
`endif

    state_t state, state_nxt;

    logic [ADDR_W-1:0] baddr_q;
    logic              mreq_q;
    logic [OFF_W-1:0]  off_q;
    logic [2:0]        op_q;
    logic [TAG_W-1:0]  tag_q;
    logic [31:0]       data_q;
    logic              adel_q;
`ifdef LOAD_MISALIGN_SPLIT_EN
    logic              span_q;
    logic [DATA_W-1:0] lo_q;
`endif

    // Decode of the incoming request, only consumed in IDLE.
    logic [1:0] amask;
    logic       reserved;
    logic       err_in;
    logic       adel_in;
`ifdef LOAD_MISALIGN_SPLIT_EN
    logic       span_in;
`else
    logic       misal_in;
`endif

    always_comb begin
        amask = 2'd0;
        case (lu.req_op)
            OP_LW:         amask = 2'd3;
            OP_LHU, OP_LH: amask = 2'd1;
            default:       amask = 2'd0;
        endcase
        reserved = (lu.req_op > OP_LH);
`ifdef LOAD_MISALIGN_SPLIT_EN
        span_in  = ({1'b0, lu.req_addr[OFF_W-1:0]} + OFF_W1'(amask)) > OFF_W1'(BYTES - 1);
        err_in   = reserved;
        adel_in  = 1'b0;
`else
        misal_in = (lu.req_addr[1:0] & amask) != 2'd0;
        err_in   = reserved | misal_in;
        adel_in  = misal_in;
`endif
    end

    // A beat's data counts only once its request handshake has completed.
    logic beat_done;
    assign beat_done = lu.mem_rvalid && !mreq_q;

    logic [BUF_W-1:0] merged;
    logic [31:0]      sel;
    logic [31:0]      ext;

    always_comb begin
`ifdef LOAD_MISALIGN_SPLIT_EN
        merged = (state == BEAT1) ? {lu.mem_rdata, lo_q} : {{DATA_W{1'b0}}, lu.mem_rdata};
`else
        merged = lu.mem_rdata;
`endif
        sel = 32'(merged >> {off_q, 3'b000});
        case (op_q)
            OP_LW:   ext = sel;
            OP_LBU:  ext = {24'd0, sel[7:0]};
            OP_LB:   ext = {{24{sel[7]}}, sel[7:0]};
            OP_LHU:  ext = {16'd0, sel[15:0]};
            OP_LH:   ext = {{16{sel[15]}}, sel[15:0]};
            default: ext = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (lu.req_valid) begin
                    state_nxt = err_in ? RESP : BEAT0;
                end
            end
            BEAT0: begin
                if (beat_done) begin
`ifdef LOAD_MISALIGN_SPLIT_EN
                    state_nxt = span_q ? BEAT1 : RESP;
`else
                    state_nxt = RESP;
`endif
                end
            end
`ifdef LOAD_MISALIGN_SPLIT_EN
            BEAT1: begin
                if (beat_done) begin
                    state_nxt = RESP;
                end
            end
`endif
            RESP: begin
                if (lu.resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baddr_q <= '0;
            mreq_q  <= 1'b0;
            off_q   <= '0;
            op_q    <= 3'd0;
            tag_q   <= '0;
            data_q  <= 32'd0;
            adel_q  <= 1'b0;
`ifdef LOAD_MISALIGN_SPLIT_EN
            span_q  <= 1'b0;
            lo_q    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (lu.req_valid) begin
                        baddr_q <= {lu.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        mreq_q  <= !err_in;
                        off_q   <= lu.req_addr[OFF_W-1:0];
                        op_q    <= lu.req_op;
                        tag_q   <= lu.req_tag;
                        data_q  <= 32'd0;
                        adel_q  <= adel_in;
`ifdef LOAD_MISALIGN_SPLIT_EN
                        span_q  <= span_in;
`endif
                    end
                end
                RESP: begin
                end
                default: begin
                    if (mreq_q) begin
                        if (lu.mem_req_ready) begin
                            mreq_q <= 1'b0;
                        end
                    end else if (lu.mem_rvalid) begin
`ifdef LOAD_MISALIGN_SPLIT_EN
                        // First half of a spanning access: park it and fetch the next beat.
                        if ((state == BEAT0) && span_q) begin
                            lo_q    <= lu.mem_rdata;
                            baddr_q <= baddr_q + ADDR_W'(BYTES);
                            mreq_q  <= 1'b1;
                        end else begin
                            data_q  <= ext;
                        end
`else
                        data_q <= ext;
`endif
                    end
                end
            endcase
        end
    end

    assign lu.req_ready     = (state == IDLE);
    assign lu.resp_valid    = (state == RESP);
    assign lu.mem_req_valid = mreq_q;
    assign lu.mem_addr      = baddr_q;
    assign lu.resp_data     = data_q;
    assign lu.resp_tag      = tag_q;
    assign lu.resp_adel     = adel_q;
endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: 32-bit and 64-bit instances, directed loads with hand-computed results,
// per-instance memory responder that checks beat addresses and a monitor that checks every held response cycle.
`timescale 1ns/1ps
module tb_load_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    load_unit_if #(.DATA_W(32), .ADDR_W(32), .TAG_W(5)) i32 ();
    load_unit_if #(.DATA_W(64), .ADDR_W(32), .TAG_W(5)) i64 ();

    load_unit #(.DATA_W(32), .ADDR_W(32), .TAG_W(5)) dut32 (.clk(clk), .reset(reset), .lu(i32));
    load_unit #(.DATA_W(64), .ADDR_W(32), .TAG_W(5)) dut64 (.clk(clk), .reset(reset), .lu(i64));

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        adel;
        int          lat;
    } exp_t;

    exp_t        rq32[$];
    exp_t        rq64[$];
    logic [31:0] aq32[$];
    logic [31:0] aq64[$];

    int nt = 0;
    int nf = 0;
    int cyc = 0;
    int ms32 = 0, ms64 = 0, rs32 = 0, rs64 = 0;
    int acc32 = 0, acc64 = 0;
    bit hs32 = 0, hs64 = 0, frv32 = 0, inr32 = 0, inr64 = 0;
    logic [31:0] ha32, ha64;
    logic [31:0] w1000, w1004;
    logic [63:0] d1000, d1008;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nt++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        nt++;
        nf++;
        $display("FAIL %s: event not expected or not seen in time", name);
    endtask

    function automatic logic [31:0] m32(input logic [31:0] a);
        if (a == 32'h1000) return w1000;
        if (a == 32'h1004) return w1004;
        return 32'hDEADBEEF;
    endfunction

    function automatic logic [63:0] m64(input logic [31:0] a);
        if (a == 32'h1000) return d1000;
        if (a == 32'h1008) return d1008;
        return 64'hDEADBEEF_DEADBEEF;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // 32-bit memory responder, response consumer and monitor
    initial begin
        i32.mem_req_ready = 1'b1;
        i32.mem_rvalid    = 1'b0;
        i32.mem_rdata     = '0;
        i32.resp_ready    = 1'b1;
        forever begin
            @(negedge clk);
            if (i32.mem_req_valid) begin
                if (aq32.size() == 0) miss("mem32_unexpected_req");
                else chk("mem32_addr", 64'(i32.mem_addr), 64'(aq32[0]));
                if (i32.mem_req_ready) begin
                    hs32 = 1'b1;
                    ha32 = i32.mem_addr;
                    if (aq32.size() != 0) void'(aq32.pop_front());
                end else if (ms32 > 0) ms32--;
            end
            if (i32.resp_valid) begin
                if (rq32.size() == 0) miss("resp32_unexpected");
                else begin
                    if (!inr32 && rq32[0].lat >= 0) chk("resp32_latency", 64'(cyc - acc32), 64'(rq32[0].lat));
                    inr32 = 1'b1;
                    chk("resp32_data", 64'(i32.resp_data), 64'(rq32[0].data));
                    chk("resp32_tag",  64'(i32.resp_tag),  64'(rq32[0].tag));
                    chk("resp32_adel", 64'(i32.resp_adel), 64'(rq32[0].adel));
                    if (i32.resp_ready) begin
                        void'(rq32.pop_front());
                        inr32 = 1'b0;
                    end else if (rs32 > 0) rs32--;
                end
            end
            @(posedge clk);
            #1;
            i32.mem_req_ready = (ms32 == 0);
            i32.resp_ready    = (rs32 == 0);
            i32.mem_rvalid    = hs32 | frv32;
            i32.mem_rdata     = hs32 ? m32(ha32) : 32'h0BAD0BAD;
            hs32 = 1'b0;
        end
    end

    // 64-bit memory responder, response consumer and monitor
    initial begin
        i64.mem_req_ready = 1'b1;
        i64.mem_rvalid    = 1'b0;
        i64.mem_rdata     = '0;
        i64.resp_ready    = 1'b1;
        forever begin
            @(negedge clk);
            if (i64.mem_req_valid) begin
                if (aq64.size() == 0) miss("mem64_unexpected_req");
                else chk("mem64_addr", 64'(i64.mem_addr), 64'(aq64[0]));
                if (i64.mem_req_ready) begin
                    hs64 = 1'b1;
                    ha64 = i64.mem_addr;
                    if (aq64.size() != 0) void'(aq64.pop_front());
                end else if (ms64 > 0) ms64--;
            end
            if (i64.resp_valid) begin
                if (rq64.size() == 0) miss("resp64_unexpected");
                else begin
                    if (!inr64 && rq64[0].lat >= 0) chk("resp64_latency", 64'(cyc - acc64), 64'(rq64[0].lat));
                    inr64 = 1'b1;
                    chk("resp64_data", 64'(i64.resp_data), 64'(rq64[0].data));
                    chk("resp64_tag",  64'(i64.resp_tag),  64'(rq64[0].tag));
                    chk("resp64_adel", 64'(i64.resp_adel), 64'(rq64[0].adel));
                    if (i64.resp_ready) begin
                        void'(rq64.pop_front());
                        inr64 = 1'b0;
                    end else if (rs64 > 0) rs64--;
                end
            end
            @(posedge clk);
            #1;
            i64.mem_req_ready = (ms64 == 0);
            i64.resp_ready    = (rs64 == 0);
            i64.mem_rvalid    = hs64;
            i64.mem_rdata     = hs64 ? m64(ha64) : 64'h0BAD0BAD_0BAD0BAD;
            hs64 = 1'b0;
        end
    end

    task automatic issue(input bit w64, input logic [31:0] addr, input logic [2:0] op, input logic [4:0] tag,
                         input logic [31:0] ed, input logic ea, input int lat, input int nb);
        exp_t        e;
        logic [31:0] b0;
        int          n;
        e.data = ed;
        e.tag  = tag;
        e.adel = ea;
        e.lat  = lat;
        b0 = w64 ? (addr & ~32'h7) : (addr & ~32'h3);
        if (w64) begin
            rq64.push_back(e);
            for (int k = 0; k < nb; k++) aq64.push_back(b0 + 32'(k * 8));
        end else begin
            rq32.push_back(e);
            for (int k = 0; k < nb; k++) aq32.push_back(b0 + 32'(k * 4));
        end
        @(posedge clk);
        #1;
        if (w64) begin
            i64.req_valid = 1'b1; i64.req_addr = addr; i64.req_op = op; i64.req_tag = tag;
        end else begin
            i32.req_valid = 1'b1; i32.req_addr = addr; i32.req_op = op; i32.req_tag = tag;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(w64 ? i64.req_ready : i32.req_ready) && n < 20);
        if (n >= 20) miss("accept_timeout");
        if (w64) acc64 = cyc; else acc32 = cyc;
        @(posedge clk);
        #1;
        // Scramble the request lines after accept; the unit must have captured them.
        if (w64) begin
            i64.req_valid = 1'b0; i64.req_addr = 32'h2FFF; i64.req_op = 3'd7; i64.req_tag = 5'h1F;
        end else begin
            i32.req_valid = 1'b0; i32.req_addr = 32'h2FFF; i32.req_op = 3'd7; i32.req_tag = 5'h1F;
        end
        n = 0;
        while ((w64 ? rq64.size() : rq32.size()) != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            miss("resp_timeout");
            rq32.delete(); rq64.delete(); aq32.delete(); aq64.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        i32.req_valid = 1'b0; i32.req_addr = '0; i32.req_op = 3'd0; i32.req_tag = '0;
        i64.req_valid = 1'b0; i64.req_addr = '0; i64.req_op = 3'd0; i64.req_tag = '0;
        w1000 = 32'h80011234;
        w1004 = 32'h0;
        d1000 = 64'h88776655_44332211;
        d1008 = 64'h00FFEEDD_CCBBAA99;
        repeat (2) @(negedge clk);
        chk("rst_req_ready",   64'(i32.req_ready), 64'd1);
        chk("rst_resp_valid",  64'(i32.resp_valid), 64'd0);
        chk("rst_mem_req",     64'(i32.mem_req_valid), 64'd0);
        chk("rst_mem_addr",    64'(i32.mem_addr), 64'd0);
        chk("rst_resp_data",   64'(i32.resp_data), 64'd0);
        chk("rst_resp_tag",    64'(i32.resp_tag), 64'd0);
        chk("rst_resp_adel",   64'(i32.resp_adel), 64'd0);
        chk("rst64_req_ready", 64'(i64.req_ready), 64'd1);
        chk("rst64_mem_req",   64'(i64.mem_req_valid), 64'd0);
        reset = 1'b0;

        // 32-bit bus, word 0x80011234 at 0x1000
        issue(0, 32'h1002, 3'd4, 5'd5,  32'hFFFF8001, 1'b0, 3, 1);
        issue(0, 32'h1003, 3'd1, 5'd6,  32'h00000080, 1'b0, 3, 1);
        issue(0, 32'h1003, 3'd2, 5'd7,  32'hFFFFFF80, 1'b0, 3, 1);
        issue(0, 32'h1000, 3'd0, 5'd8,  32'h80011234, 1'b0, 3, 1);
        issue(0, 32'h1000, 3'd3, 5'd9,  32'h00001234, 1'b0, 3, 1);
        issue(0, 32'h1000, 3'd6, 5'd10, 32'h00000000, 1'b0, 1, 0);

        w1000 = 32'h44332211;
        w1004 = 32'h88776655;
        issue(0, 32'h1003, 3'd2, 5'd11, 32'h00000044, 1'b0, 3, 1);
`ifdef LOAD_MISALIGN_SPLIT_EN
        issue(0, 32'h1003, 3'd0, 5'd12, 32'h77665544, 1'b0, 5, 2);
        issue(0, 32'h1001, 3'd4, 5'd13, 32'h00003322, 1'b0, 3, 1);
        issue(0, 32'h1003, 3'd3, 5'd14, 32'h00005544, 1'b0, 5, 2);
`else
        issue(0, 32'h1003, 3'd0, 5'd12, 32'h00000000, 1'b1, 1, 0);
        issue(0, 32'h1001, 3'd4, 5'd13, 32'h00000000, 1'b1, 1, 0);
        issue(0, 32'h1003, 3'd3, 5'd14, 32'h00000000, 1'b1, 1, 0);
`endif

        // 64-bit bus: first load stalls the beat request 3 cycles and the response 2 cycles
        ms64 = 3;
        rs64 = 2;
        issue(1, 32'h1004, 3'd0, 5'h1A, 32'h88776655, 1'b0, 6, 1);
        issue(1, 32'h1006, 3'd4, 5'h1B, 32'hFFFF8877, 1'b0, 3, 1);
        issue(1, 32'h1007, 3'd2, 5'h1C, 32'hFFFFFF88, 1'b0, 3, 1);
`ifdef LOAD_MISALIGN_SPLIT_EN
        issue(1, 32'h1006, 3'd0, 5'h1D, 32'hAA998877, 1'b0, 5, 2);
        issue(1, 32'h1003, 3'd4, 5'h1E, 32'h00005544, 1'b0, 3, 1);
`else
        issue(1, 32'h1006, 3'd0, 5'h1D, 32'h00000000, 1'b1, 1, 0);
        issue(1, 32'h1003, 3'd4, 5'h1E, 32'h00000000, 1'b1, 1, 0);
`endif

        // Reset while a beat request is pending, then a stray mem_rvalid
        ms32 = 50;
        aq32.push_back(32'h1000);
        @(posedge clk);
        #1;
        i32.req_valid = 1'b1; i32.req_addr = 32'h1000; i32.req_op = 3'd2; i32.req_tag = 5'd3;
        @(posedge clk);
        #1;
        i32.req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_beat0_pending", 64'(i32.mem_req_valid), 64'd1);
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ms32 = 0;
        aq32.delete();
        frv32 = 1'b1;
        @(negedge clk);
        frv32 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_mid_resp_valid", 64'(i32.resp_valid), 64'd0);
            chk("rst_mid_req_ready",  64'(i32.req_ready), 64'd1);
            chk("rst_mid_mem_req",    64'(i32.mem_req_valid), 64'd0);
        end

        repeat (2) @(negedge clk);
        chk("queues_drained", 64'(rq32.size() + rq64.size() + aq32.size() + aq64.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end
endmodule

// File: doc/load_unit.md
# load_unit

Parametrised, sequential load unit for the memory stage. It accepts one load request at a time, issues aligned beat reads on a bus of configurable width, and merges up to two beats when a misaligned access spans a beat boundary. It then returns the byte-selected, zero/sign-extended 32-bit result to writeback with a ready/valid handshake. It generalises the combinational load extender with bus width, a tag, back-pressure and misaligned-access handling.

## Interface
- `DATA_W`, default 32: memory bus width in bits; legal values 32 or 64; `BYTES = DATA_W/8`.
- `ADDR_W`, default 32: byte address width.
- `TAG_W`, default 5: destination-register tag width.
- `clk` in 1: clock; everything is sampled on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: load request present.
- `req_ready` out 1: unit can accept a request.
- `req_addr` in ADDR_W: byte address.
- `req_op` in 3: 0 lw, 1 lbu, 2 lb, 3 lhu, 4 lh; 5–7 reserved.
- `req_tag` in TAG_W: passed through unchanged to `resp_tag`.
- `mem_req_valid` out 1: beat read request.
- `mem_req_ready` in 1: memory accepts the beat request.
- `mem_addr` out ADDR_W: beat address; low log2(BYTES) bits are always 0.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in DATA_W: read data, little-endian byte lanes.
- `resp_valid` out 1: result available.
- `resp_ready` in 1: consumer takes the result.
- `resp_data` out 32: extended load result.
- `resp_tag` out TAG_W: tag of the request.
- `resp_adel` out 1: address-error-on-load flag.

## Operation
- Size S: lw = 4 bytes; lh/lhu = 2 bytes; lb/lbu = 1 byte. Offset `off = req_addr mod BYTES`.
- Misaligned: `req_addr mod S != 0`. Spanning: `off + S > BYTES`.
- FSM states:
  - IDLE: `req_ready=1`.
  - BEAT0: issue beat at `req_addr` rounded down to a beat; then wait for data.
  - BEAT1: issue beat at the beat-0 address + BYTES; then wait for data.
  - RESP: hold the response.
- Transitions:
  - IDLE→BEAT0 on accept, for a legal, non-reserved request.
  - IDLE→RESP on accept, for a reserved op or an address error. No memory access occurs.
  - BEAT0→BEAT1 on data return when the access is spanning.
  - BEAT0→RESP on data return when it is not spanning.
  - BEAT1→RESP on data return.
  - RESP→IDLE when `resp_valid && resp_ready`.
- Per beat, `mem_req_valid` is held high until `mem_req_ready`, then drops. Exactly one beat is outstanding at a time.
- `mem_rvalid` counts only after that beat's request handshake; it is ignored in IDLE and RESP and while a request is still pending.
- Merge buffer is 2·DATA_W bits, {beat1, beat0}. Result bytes are taken from byte index `off` upward, then zero-extended (lbu/lhu) or sign-extended from the top selected byte (lb/lh).
- Reserved op: `resp_data=0`, `resp_adel=0`.
- Request fields are captured at accept; later changes on `req_*` have no effect.

## Timing
- Reset value of every output is 0 except `req_ready`, which is 1 (IDLE).
- Reset mid-operation: the FSM returns to IDLE, the buffer is cleared, and any in-flight `mem_rvalid` is ignored.
- Best-case latency: accept in cycle 0; `mem_req_valid` in cycle 1; `mem_rvalid` in cycle 2; `resp_valid` in cycle 3.
- A spanning access adds the full round trip of the second beat.
- Error/reserved path: `resp_valid` in the cycle after accept.
- `resp_*` is registered and stable while `resp_valid && !resp_ready`.
- New accepts are possible only from IDLE. Back-to-back throughput is one load per (latency + 1) cycles.

## Configuration
- `LOAD_MISALIGN_SPLIT_EN` defined:
  - Misaligned accesses are legal.
  - Non-spanning ones use one beat; spanning ones use two beats and are merged.
  - `resp_adel` is never set.
- Not defined:
  - Any misaligned lw/lh/lhu completes via the error path with `resp_adel=1`, `resp_data=0`, and no `mem_req_valid`.
  - The BEAT1 state and the upper half of the merge buffer are absent.

## Test plan
- DATA_W=32: lh @0x1002, word@0x1000=0x80011234 → one beat at 0x1000, `resp_data`=0xFFFF8001, tag echoed, resp_valid at cycle 3.
- DATA_W=32: lbu @0x1003, same word → 0x00000080; lb @0x1003 → 0xFFFFFF80.
- Split enabled, DATA_W=32: lw @0x1003, word@0x1000=0x44332211, word@0x1004=0x88776655 → beats at 0x1000 then 0x1004, result 0x77665544, `resp_adel`=0.
- Split disabled: lw @0x1003 → no `mem_req_valid`, `resp_valid` the cycle after accept, `resp_adel`=1, data 0; lb @0x1003 proceeds normally.
- DATA_W=64: lw @0x1004, beat@0x1000=0x8877665544332211 → `mem_addr`=0x1000, result 0x88776655. Stall `mem_req_ready` for 3 cycles and `resp_ready` for 2 cycles → outputs held stable.
- Assert `reset` while in BEAT0, then pulse `mem_rvalid` → unit stays in IDLE, `resp_valid`=0, `req_ready`=1.
